// File: rtl/jc_pkg.sv
// Opcodes and return-stack entry layout shared by the jump control unit and its stack.
package jc_pkg;

   localparam logic [3:0] OP_JF   = 4'h8;
   localparam logic [3:0] OP_JNF  = 4'h9;
   localparam logic [3:0] OP_EI   = 4'hA;
   localparam logic [3:0] OP_DI   = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_CALL = 4'hD;
   localparam logic [3:0] OP_RET  = 4'hE;
   localparam logic [3:0] OP_RETI = 4'hF;

   // Upper part of a stack entry; the return address sits below it.
   typedef struct packed {
      logic       irq_frame;
      logic [3:0] flags;
   } jc_frame_t;

   localparam int JC_FRAME_W = $bits(jc_frame_t);

   function automatic int jc_entry_w(input int aw);
      return JC_FRAME_W + aw;
   endfunction

endpackage

// File: rtl/jc_ret_stack.sv
// jc_ret_stack: DEPTH-entry LIFO, pop data is the current top (combinational), push/pop commit on the clock edge.
// A push when full or a pop when empty is dropped and flagged on ovf_o/unf_o in the same cycle.
module jc_ret_stack #(
   parameter int DW    = 13,
   parameter int DEPTH = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [DW-1:0] push_dat_i,
   output logic [DW-1:0] pop_dat_o,
   output logic          full_o,
   output logic          empty_o,
   output logic          ovf_o,
   output logic          unf_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_idx, rd_idx;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign ovf_o   = push_i & full_o;
   assign unf_o   = pop_i & empty_o;

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o & ~push_i;

   assign wr_idx    = PW'(cnt_q);
   assign rd_idx    = PW'(cnt_q - CW'(1));
   assign pop_dat_o = mem_q[rd_idx];

   always_comb begin
      cnt_d = cnt_q;
      if (do_push)
         cnt_d = cnt_q + CW'(1);
      else if (do_pop)
         cnt_d = cnt_q - CW'(1);
   end

   // Only the count is reset; stale entries are unreachable once it is zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   always_ff @(posedge clk_i) begin
      if (do_push)
         mem_q[wr_idx] <= push_dat_i;
   end

endmodule

// File: rtl/jump_ctrl_unit.sv
// jump_ctrl_unit: fetch-stage jump/branch/interrupt control; inputs sampled each edge, all outputs registered (1 cycle).
// JC_NESTED_IRQ_EN: when defined, a higher-priority line may preempt a running ISR.
module jump_ctrl_unit #(
   parameter int            AW       = 8,
   parameter int            INS_W    = 24,
   parameter int            N_IRQ    = 4,
   parameter int            STACK_D  = 4,
   parameter logic [AW-1:0] VEC_BASE = AW'('hF0)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [INS_W-1:0] ins,
   input  logic [AW-1:0]    cur_addr,
   input  logic [3:0]       flag_ex,
   input  logic [N_IRQ-1:0] irq,
   output logic [AW-1:0]    jmp_loc,
   output logic             pc_mux_sel,
   output logic [N_IRQ-1:0] irq_ack,
   output logic [3:0]       flag_restore,
   output logic             flag_restore_vld,
   output logic             stack_err
);

   import jc_pkg::*;

   localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
   localparam int EW = jc_entry_w(AW);

   logic [AW-1:0]    jmp_loc_q, jmp_loc_d;
   logic             pc_sel_q, pc_sel_d;
   logic [N_IRQ-1:0] ack_q, ack_d;
   logic [3:0]       fr_q, fr_d;
   logic             frv_q, frv_d;
   logic             err_q, err_d;
   logic             int_en_q, int_en_d;
   logic [N_IRQ-1:0] isv_q, isv_d;

   logic [3:0]       opc;
   logic [1:0]       cond;
   logic [AW-1:0]    tgt;
   logic             unused_ins;

   logic             irq_any, isv_any, irq_take;
   logic [IW-1:0]    irq_idx, isv_idx;

   logic             push, pop, full, empty, ovf, unf;
   logic [EW-1:0]    push_dat, pop_dat;
   jc_frame_t        pop_fr;
   logic [AW-1:0]    pop_addr;

   assign opc        = ins[INS_W-1 -: 4];
   assign cond       = ins[INS_W-5 -: 2];
   assign tgt        = ins[AW-1:0];
   assign unused_ins = ^ins[INS_W-7:AW];

   assign pop_fr   = pop_dat[EW-1:AW];
   assign pop_addr = pop_dat[AW-1:0];

   // Lowest index wins for both pending and in-service lines.
   always_comb begin
      irq_any = 1'b0;
      irq_idx = '0;
      isv_any = 1'b0;
      isv_idx = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (irq[i]) begin
            irq_any = 1'b1;
            irq_idx = IW'(i);
         end
         if (isv_q[i]) begin
            isv_any = 1'b1;
            isv_idx = IW'(i);
         end
      end
   end

`ifdef JC_NESTED_IRQ_EN
   assign irq_take = int_en_q && irq_any && (!isv_any || (irq_idx < isv_idx));
`else
   assign irq_take = int_en_q && irq_any && !isv_any;
`endif

   // While pc_mux_sel is high the instruction is stale: nothing is decoded or accepted.
   always_comb begin
      jmp_loc_d = jmp_loc_q;
      pc_sel_d  = 1'b0;
      ack_d     = '0;
      fr_d      = fr_q;
      frv_d     = 1'b0;
      int_en_d  = int_en_q;
      isv_d     = isv_q;
      push      = 1'b0;
      pop       = 1'b0;
      push_dat  = '0;
      if (!pc_sel_q) begin
         if (irq_take) begin
            push           = 1'b1;
            push_dat       = {1'b1, flag_ex, cur_addr};
            jmp_loc_d      = VEC_BASE + AW'(irq_idx);
            pc_sel_d       = 1'b1;
            ack_d[irq_idx] = 1'b1;
            isv_d[irq_idx] = 1'b1;
         end else begin
            case (opc)
               OP_JMP: begin
                  jmp_loc_d = tgt;
                  pc_sel_d  = 1'b1;
               end
               OP_JF: begin
                  if (flag_ex[cond]) begin
                     jmp_loc_d = tgt;
                     pc_sel_d  = 1'b1;
                  end
               end
               OP_JNF: begin
                  if (!flag_ex[cond]) begin
                     jmp_loc_d = tgt;
                     pc_sel_d  = 1'b1;
                  end
               end
               OP_CALL: begin
                  push      = 1'b1;
                  push_dat  = {1'b0, 4'h0, cur_addr + AW'(1)};
                  jmp_loc_d = tgt;
                  pc_sel_d  = 1'b1;
               end
               OP_RET, OP_RETI: begin
                  pop = 1'b1;
                  if (!empty) begin
                     jmp_loc_d = pop_addr;
                     pc_sel_d  = 1'b1;
                     if (opc == OP_RETI) begin
                        if (pop_fr.irq_frame) begin
                           fr_d  = pop_fr.flags;
                           frv_d = 1'b1;
                        end
                        if (isv_any)
                           isv_d[isv_idx] = 1'b0;
                     end
                  end
               end
               OP_EI:   int_en_d = 1'b1;
               OP_DI:   int_en_d = 1'b0;
               default: ;
            endcase
         end
      end
      err_d = err_q | ovf | unf;
   end

   jc_ret_stack #(
      .DW    (EW),
      .DEPTH (STACK_D)
   ) u_stack (
      .clk_i      (clk),
      .rst_ni     (reset),
      .push_i     (push),
      .pop_i      (pop),
      .push_dat_i (push_dat),
      .pop_dat_o  (pop_dat),
      .full_o     (full),
      .empty_o    (empty),
      .ovf_o      (ovf),
      .unf_o      (unf)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         jmp_loc_q <= '0;
         pc_sel_q  <= 1'b0;
         ack_q     <= '0;
         fr_q      <= '0;
         frv_q     <= 1'b0;
         err_q     <= 1'b0;
         int_en_q  <= 1'b1;
         isv_q     <= '0;
      end else begin
         jmp_loc_q <= jmp_loc_d;
         pc_sel_q  <= pc_sel_d;
         ack_q     <= ack_d;
         fr_q      <= fr_d;
         frv_q     <= frv_d;
         err_q     <= err_d;
         int_en_q  <= int_en_d;
         isv_q     <= isv_d;
      end
   end

   assign jmp_loc          = jmp_loc_q;
   assign pc_mux_sel       = pc_sel_q;
   assign irq_ack          = ack_q;
   assign flag_restore     = fr_q;
   assign flag_restore_vld = frv_q;
   assign stack_err        = err_q;

endmodule

// File: tb/tb_jump_ctrl_unit.sv
// Directed and randomized bench for jump_ctrl_unit against a queue-based reference model.
module tb_jump_ctrl_unit;

`ifdef JC_NESTED_IRQ_EN
   localparam bit NESTED = 1'b1;
`else
   localparam bit NESTED = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] ins;
   logic [7:0]  cur_addr;
   logic [3:0]  flag_ex;
   logic [3:0]  irq;
   logic [7:0]  jmp_loc;
   logic        pc_mux_sel;
   logic [3:0]  irq_ack;
   logic [3:0]  flag_restore;
   logic        flag_restore_vld;
   logic        stack_err;

   jump_ctrl_unit dut (
      .clk              (clk),
      .reset            (reset),
      .ins              (ins),
      .cur_addr         (cur_addr),
      .flag_ex          (flag_ex),
      .irq              (irq),
      .jmp_loc          (jmp_loc),
      .pc_mux_sel       (pc_mux_sel),
      .irq_ack          (irq_ack),
      .flag_restore     (flag_restore),
      .flag_restore_vld (flag_restore_vld),
      .stack_err        (stack_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       frame;
      bit [3:0] flags;
      bit [7:0] addr;
   } ent_t;

   ent_t     stk[$];
   bit [7:0] m_jl;
   bit       m_sel;
   bit [3:0] m_ack;
   bit [3:0] m_fr;
   bit       m_frv;
   bit       m_err;
   bit       m_en;
   bit [3:0] m_isv;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      stk.delete();
      m_jl = 0; m_sel = 0; m_ack = 0; m_fr = 0; m_frv = 0; m_err = 0; m_en = 1; m_isv = 0;
   endtask

   task automatic model_push(input bit frame, input bit [3:0] fl, input bit [7:0] a);
      ent_t e;
      e.frame = frame; e.flags = fl; e.addr = a;
      if (stk.size() >= 4) m_err = 1;
      else stk.push_back(e);
   endtask

   // One clock edge of architectural behaviour, from the current inputs.
   task automatic model_edge();
      int       hi, svc;
      bit       shadow;
      bit [3:0] op;
      ent_t     e;
      shadow = m_sel;
      m_sel = 0; m_ack = 0; m_frv = 0;
      if (shadow) return;
      hi = -1; svc = -1;
      for (int i = 0; i < 4; i++) begin
         if (irq[i] && hi < 0) hi = i;
         if (m_isv[i] && svc < 0) svc = i;
      end
      if (m_en && hi >= 0 && (svc < 0 || (NESTED && hi < svc))) begin
         model_push(1'b1, flag_ex, cur_addr);
         m_jl = 8'hF0 + 8'(hi); m_sel = 1; m_ack[hi] = 1; m_isv[hi] = 1;
         return;
      end
      op = ins[23:20];
      case (op)
         4'hC: begin m_jl = ins[7:0]; m_sel = 1; end
         4'h8: if (flag_ex[ins[19:18]] == 1'b1) begin m_jl = ins[7:0]; m_sel = 1; end
         4'h9: if (flag_ex[ins[19:18]] == 1'b0) begin m_jl = ins[7:0]; m_sel = 1; end
         4'hD: begin
            model_push(1'b0, 4'h0, cur_addr + 8'd1);
            m_jl = ins[7:0]; m_sel = 1;
         end
         4'hE, 4'hF: begin
            if (stk.size() == 0) m_err = 1;
            else begin
               e = stk.pop_back();
               m_jl = e.addr; m_sel = 1;
               if (op == 4'hF) begin
                  if (e.frame) begin m_fr = e.flags; m_frv = 1; end
                  if (svc >= 0) m_isv[svc] = 0;
               end
            end
         end
         4'hA: m_en = 1;
         4'hB: m_en = 0;
         default: ;
      endcase
   endtask

   task automatic compare_all();
      check("jmp_loc", jmp_loc, m_jl);
      check("pc_mux_sel", pc_mux_sel, m_sel);
      check("irq_ack", irq_ack, m_ack);
      check("flag_restore", flag_restore, m_fr);
      check("flag_restore_vld", flag_restore_vld, m_frv);
      check("stack_err", stack_err, m_err);
   endtask

   task automatic drive(input logic [23:0] i, input logic [7:0] a, input logic [3:0] f, input logic [3:0] q);
      ins = i; cur_addr = a; flag_ex = f; irq = q;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_jmp_loc"}, jmp_loc, 8'h00);
      check({tag, "_sel"}, pc_mux_sel, 1'b0);
      check({tag, "_ack"}, irq_ack, 4'h0);
      check({tag, "_fr"}, flag_restore, 4'h0);
      check({tag, "_frv"}, flag_restore_vld, 1'b0);
      check({tag, "_err"}, stack_err, 1'b0);
   endtask

   // Asynchronous reset taken mid-run; outputs must clear before any clock edge.
   task automatic do_reset();
      reset = 1'b0;
      #2;
      model_reset();
      check_reset_vals("async_rst");
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   bit [3:0] ops [10] = '{4'hC, 4'h8, 4'h9, 4'hD, 4'hE, 4'hF, 4'hA, 4'hA, 4'hB, 4'h0};

   initial begin
      reset = 1'b0;
      drive(24'h000000, 8'h00, 4'h0, 4'h0);
      model_reset();
      #200;
      check_reset_vals("reset");
      reset = 1'b1;

      // Unconditional jump and its shadow cycle.
      drive(24'hC00008, 8'h00, 4'h0, 4'h0);
      step(); check("jmp_sel", pc_mux_sel, 1'b1); check("jmp_loc8", jmp_loc, 8'h08);
      step(); check("shadow_sel", pc_mux_sel, 1'b0);

      // Conditional jumps.
      drive(24'h800008, 8'h00, 4'h0, 4'h0);
      step(); check("jf_not_taken", pc_mux_sel, 1'b0);
      drive(24'h900008, 8'h00, 4'h0, 4'h0);
      step(); check("jnf_taken", pc_mux_sel, 1'b1); check("jnf_loc", jmp_loc, 8'h08);
      drive(24'h000000, 8'h00, 4'h0, 4'h0); step();
      drive(24'h800008, 8'h00, 4'h1, 4'h0);
      step(); check("jf_taken", pc_mux_sel, 1'b1);
      drive(24'h000000, 8'h00, 4'h0, 4'h0); step();

      // Interrupt entry and RETI with flag restore.
      drive(24'h000000, 8'h01, 4'h5, 4'b0100);
      step(); check("irq2_loc", jmp_loc, 8'hF2); check("irq2_ack", irq_ack, 4'b0100);
      drive(24'h000000, 8'h02, 4'h0, 4'h0); step();
      drive(24'hF00000, 8'h30, 4'h0, 4'h0);
      step(); check("reti_loc", jmp_loc, 8'h01); check("reti_fr", flag_restore, 4'h5);
      check("reti_frv", flag_restore_vld, 1'b1);
      drive(24'h000000, 8'h00, 4'h0, 4'h0); step();

      // Priority while another line is in service.
      do_reset();
      drive(24'h000000, 8'h10, 4'h3, 4'b1000);
      step(); check("irq3_ack", irq_ack, 4'b1000); check("irq3_loc", jmp_loc, 8'hF3);
      drive(24'h000000, 8'h11, 4'h0, 4'b0001);
      step(); check("shadow_no_ack", irq_ack, 4'h0);
      step();
`ifdef JC_NESTED_IRQ_EN
      check("nest_ack", irq_ack, 4'b0001); check("nest_loc", jmp_loc, 8'hF0);
`else
      check("nonest_ack", irq_ack, 4'b0000); check("nonest_sel", pc_mux_sel, 1'b0);
`endif
      drive(24'hF00000, 8'h12, 4'h0, 4'b0001); step();
      step();
      drive(24'hF00000, 8'h13, 4'h0, 4'b0001); step();
`ifndef JC_NESTED_IRQ_EN
      check("after_reti_ack", irq_ack, 4'b0001); check("after_reti_loc", jmp_loc, 8'hF0);
`endif
      drive(24'h000000, 8'h00, 4'h0, 4'h0); step();

      // Stack overflow then underflow.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive({4'hD, 12'h000, 8'h40 + 8'(i)}, 8'h20 + 8'(i), 4'h0, 4'h0);
         step();
         check("call_sel", pc_mux_sel, 1'b1);
         check("call_err", stack_err, (i == 4) ? 1'b1 : 1'b0);
         drive(24'h000000, 8'h00, 4'h0, 4'h0); step();
      end
      for (int i = 0; i < 5; i++) begin
         drive(24'hE00000, 8'h50, 4'h0, 4'h0);
         step();
         if (i < 4) begin
            check("ret_loc", jmp_loc, 8'h24 - 8'(i));
            drive(24'h000000, 8'h00, 4'h0, 4'h0); step();
         end else begin
            check("ret_unf_sel", pc_mux_sel, 1'b0);
            check("ret_unf_err", stack_err, 1'b1);
         end
      end

      // DI masks interrupts; EI re-enables from the following sample.
      do_reset();
      drive(24'hB00000, 8'h00, 4'h0, 4'h0); step();
      drive(24'h000000, 8'h00, 4'h0, 4'b0001);
      step(); check("di_no_ack", irq_ack, 4'h0);
      step(); check("di_no_ack2", irq_ack, 4'h0);
      drive(24'hA00000, 8'h00, 4'h0, 4'b0001);
      step(); check("ei_cycle_no_ack", irq_ack, 4'h0);
      drive(24'h000000, 8'h00, 4'h0, 4'b0001);
      step(); check("ei_ack", irq_ack, 4'b0001); check("ei_loc", jmp_loc, 8'hF0);

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         drive({ops[$urandom_range(0, 9)], 12'($urandom), 8'($urandom)},
               8'($urandom), 4'($urandom),
               ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0);
         if ($urandom_range(0, 499) == 0) do_reset();
         else step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/jump_ctrl_unit.md
# jump_ctrl_unit

Parametrised jump/branch and interrupt control unit for the processor's fetch stage, successor to the single-interrupt jump controller. Each cycle it decodes the current instruction and pending interrupt lines, and registers a PC-mux select and target address. It supports N prioritised interrupt vectors, CALL/RET and RETI through a hardware return stack with flag save/restore, and global interrupt enable/disable.

## Interface
- AW, 8, program address width
- INS_W, 24, instruction width; opcode = ins[INS_W-1:INS_W-4], cond = ins[INS_W-5:INS_W-6], target = ins[AW-1:0]
- N_IRQ, 4, interrupt lines; index 0 highest priority
- STACK_D, 4, return-stack depth (power of two)
- VEC_BASE, 8'hF0, ISR vector for line i = VEC_BASE + i (mod 2^AW)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- ins  in  INS_W  instruction in execute
- cur_addr  in  AW  address of ins
- flag_ex  in  4  ALU flags
- irq  in  N_IRQ  level-sensitive interrupt requests
- jmp_loc  out  AW  registered jump target
- pc_mux_sel  out  1  registered; 1 = PC loads jmp_loc
- irq_ack  out  N_IRQ  one-hot, one-cycle acknowledge
- flag_restore  out  4  flags popped by RETI
- flag_restore_vld  out  1  one-cycle strobe with flag_restore
- stack_err  out  1  sticky overflow/underflow

## Operation
- Opcodes: C JMP; 8 JF (jump if flag_ex[cond] = 1); 9 JNF (jump if flag_ex[cond] = 0); D CALL (push cur_addr+1, jump); E RET (pop, jump); F RETI (pop, jump, restore flags, clear in-service bit); A EI; B DI; others are no-ops.
- Stack entry = {irq_frame, flags[3:0], addr[AW-1:0]}. CALL pushes irq_frame=0 and flags=0; interrupt entry pushes irq_frame=1, flag_ex, cur_addr.
- Interrupt accept: int_en=1, line i is the highest-priority asserted line, and no line is in service (or, with nesting, i outranks every in-service line). Accept: push frame, jmp_loc=VEC_BASE+i, irq_ack[i]=1, set in_service[i]. ins is not executed and is re-executed after RETI.
- Interrupt beats any instruction jump in the same cycle.
- RETI clears the highest-priority set bit of in_service; flag_restore_vld=1 only if the popped irq_frame=1. RET on an irq frame still pops and jumps, with no flag restore.
- Overflow (push when full): push dropped, jump still taken, stack_err=1.
- Underflow (pop when empty): no jump, pc_mux_sel=0, stack_err=1.
- stack_err clears only on reset.
- Reset: jmp_loc=0, pc_mux_sel=0, irq_ack=0, flag_restore=0, flag_restore_vld=0, stack_err=0, stack empty, in_service=0, int_en=1.

## Timing
- Inputs are sampled at edge k; all outputs are registered and valid for exactly cycle k+1. pc_mux_sel, irq_ack and flag_restore_vld are single-cycle pulses.
- Shadow cycle: in the cycle pc_mux_sel=1, ins is stale. It is treated as a no-op and irq is not accepted.
- EI/DI take effect for sampling at edge k+1.
- Stack push/pop commits at edge k. Back-to-back CALLs separated by a shadow cycle are fine.
- Async reset asserted mid-operation returns everything to reset values immediately, and the stack is discarded.

## Configuration
- JC_NESTED_IRQ_EN defined: a higher-priority line preempts a running ISR; in_service may hold several bits.
- JC_NESTED_IRQ_EN undefined: no interrupt is accepted while in_service != 0; lines stay pending until RETI.

## Structure
- Package jc_pkg: opcode constants (OP_JMP, OP_JF, OP_JNF, OP_CALL, OP_RET, OP_RETI, OP_EI, OP_DI) and the stack-entry struct/width.
- Sub-module jc_ret_stack: a STACK_D-deep LIFO with push/pop/full/empty that reports overflow/underflow. Priority encode and decode stay in the top level.

## Test plan
- Reset low 200 ns, then high; ins=24'hC00008 -> next cycle pc_mux_sel=1, jmp_loc=8'h08. The following cycle (shadow) pc_mux_sel=0 despite the same ins.
- flag_ex=4'h0: ins=24'h800008 -> pc_mux_sel=0. ins=24'h900008 -> jump to 8'h08. flag_ex=4'h1 with ins=24'h800008 -> jump.
- cur_addr=8'h01, irq=4'b0100 -> jmp_loc=8'hF2, irq_ack=4'b0100. Later ins=24'hF00000 -> jmp_loc=8'h01, flag_restore equals the saved flag_ex, flag_restore_vld=1.
- irq=4'b1000 in service, then irq=4'b0001 -> with JC_NESTED_IRQ_EN, jump to 8'hF0; without it, no jump until RETI, then 8'hF0.
- Five CALLs with STACK_D=4 -> fifth still jumps, stack_err=1. Five RETs -> fifth gives pc_mux_sel=0.
- DI (24'hB00000), then irq=4'b0001 -> no ack. EI -> ack on the cycle after EI is sampled.
